// File: rtl/csr_control_pipe.sv
// csr_control_pipe
//   Zicsr decode-stage control override with a PIPE_DEPTH-stage enable pipe to the CSR file port.
//   At decode, SYSTEM CSR ops override the base ALU/regfile controls. Their read/write/set/clear
//   enables then travel down a shift pipe and reach the CSR port at writeback. Ops are flagged
//   illegal when they modify a read-only CSR or use funct3==100. Any CSR op is held while an
//   older CSR write is still in flight.
//
//   Configuration macro: CSR_PRIV_CHECK_EN. When it is defined, an op is also illegal if
//   priv < csr_address[9:8].
//
// Ports
//   clock, reset                  core clock, asynchronous active-high reset
//   opcode_decode/funct3/rs1/rd   decode-stage instruction fields
//   csr_address, priv             CSR number and current privilege (11 M, 01 S, 00 U)
//   valid_decode                  decode slot holds a real instruction
//   stall_in, flush               downstream freeze / kill all in-flight entries
//   *_base                        base controls, passed through for non-CSR ops
//   extend_sel..regWrite          overridden decode controls (combinational)
//   csr_stall                     hold decode: CSR op behind an in-flight CSR write
//   CSR_*_en, CSR_address_wb      pipe-output enables and address
//   csr_illegal                   illegal op at pipe output
//   scan                          debug print of pipe state (simulation only)
module csr_control_pipe #(
  parameter int unsigned CORE            = 0,
  parameter int unsigned SCAN_CYCLES_MIN = 0,
  parameter int unsigned SCAN_CYCLES_MAX = 1000,
  parameter int unsigned PIPE_DEPTH      = 2    // legal range 1..4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode_decode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rd,
  input  logic [11:0] csr_address,
  input  logic [1:0]  priv,
  input  logic        valid_decode,
  input  logic        stall_in,
  input  logic        flush,
  input  logic [1:0]  extend_sel_base,
  input  logic [1:0]  operand_A_sel_base,
  input  logic        operand_B_sel_base,
  input  logic [5:0]  ALU_operation_base,
  input  logic        regWrite_base,
  output logic [1:0]  extend_sel,
  output logic [1:0]  operand_A_sel,
  output logic        operand_B_sel,
  output logic [5:0]  ALU_operation,
  output logic        regWrite,
  output logic        csr_stall,
  output logic        CSR_read_en,
  output logic        CSR_write_en,
  output logic        CSR_set_en,
  output logic        CSR_clear_en,
  output logic [11:0] CSR_address_wb,
  output logic        csr_illegal,
  input  logic        scan
);

  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic        r;
    logic        w;
    logic        s;
    logic        c;
    logic        ill;
    logic [11:0] addr;
  } entry_t;

  entry_t pipe_q [PIPE_DEPTH];
  entry_t pipe_d [PIPE_DEPTH];
  entry_t new_entry;
  entry_t out_entry;

  logic is_system, csr_op, f3_bad, csr_like;
  logic raw_r, raw_w, raw_s, raw_c;
  logic ro_viol, priv_viol, illegal;
  logic inflight_wr;

  // Instruction classification
  always_comb begin
    is_system = valid_decode & (opcode_decode == OpSystem);
    csr_op    = is_system & (funct3[1:0] != 2'b00);
    f3_bad    = is_system & (funct3 == 3'b100);
    // f3_bad still occupies a pipe slot so its illegal flag reaches writeback
    csr_like  = csr_op | f3_bad;
  end

  // Raw enables before legality; rd==0 suppresses the RW read, rs1==0 suppresses set/clear
  always_comb begin
    raw_r = 1'b0;
    raw_w = 1'b0;
    raw_s = 1'b0;
    raw_c = 1'b0;
    unique case (funct3[1:0])
      2'b01: begin
        raw_w = 1'b1;
        raw_r = (rd != 5'd0);
      end
      2'b10: begin
        raw_r = 1'b1;
        raw_s = (rs1 != 5'd0);
      end
      2'b11: begin
        raw_r = 1'b1;
        raw_c = (rs1 != 5'd0);
      end
      default: ;
    endcase
  end

`ifdef CSR_PRIV_CHECK_EN
  always_comb priv_viol = (priv < csr_address[9:8]);
`else
  logic unused_priv;
  always_comb begin
    priv_viol   = 1'b0;
    unused_priv = ^priv;
  end
`endif

  always_comb begin
    ro_viol = (raw_w | raw_s | raw_c) & (csr_address[11:10] == 2'b11);
    illegal = f3_bad | (csr_op & (ro_viol | priv_viol));
  end

  // Serialise behind any write still ahead of the output stage
  always_comb begin
    inflight_wr = 1'b0;
    for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) begin
      if (pipe_q[i].valid & (pipe_q[i].w | pipe_q[i].s | pipe_q[i].c)) inflight_wr = 1'b1;
    end
    csr_stall = csr_op & inflight_wr;
  end

  // Decode-stage control override
  always_comb begin
    extend_sel    = extend_sel_base;
    operand_A_sel = operand_A_sel_base;
    operand_B_sel = operand_B_sel_base;
    ALU_operation = ALU_operation_base;
    regWrite      = regWrite_base;
    if (csr_like) begin
      if (funct3[2]) begin
        extend_sel    = 2'd2;
        operand_A_sel = 2'd3;
        operand_B_sel = 1'b1;
        ALU_operation = 6'd0;
      end else begin
        extend_sel    = 2'd0;
        operand_A_sel = 2'd0;
        operand_B_sel = 1'b0;
        ALU_operation = 6'd1;
      end
      regWrite = (rd != 5'd0) & ~illegal & ~csr_stall;
    end
  end

  // Entry for stage 0; a held op inserts a bubble
  always_comb begin
    new_entry       = '0;
    new_entry.valid = csr_like & ~csr_stall;
    new_entry.r     = csr_op & raw_r & ~illegal;
    new_entry.w     = csr_op & raw_w & ~illegal;
    new_entry.s     = csr_op & raw_s & ~illegal;
    new_entry.c     = csr_op & raw_c & ~illegal;
    new_entry.ill   = illegal;
    new_entry.addr  = csr_address;
  end

  // Flush beats stall_in; stall_in freezes every stage
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_d[i] = '0;
    end else if (!stall_in) begin
      pipe_d[0] = new_entry;
      for (int i = 1; i < int'(PIPE_DEPTH); i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    out_entry      = pipe_q[PIPE_DEPTH-1];
    CSR_read_en    = out_entry.valid & out_entry.r;
    CSR_write_en   = out_entry.valid & out_entry.w;
    CSR_set_en     = out_entry.valid & out_entry.s;
    CSR_clear_en   = out_entry.valid & out_entry.c;
    csr_illegal    = out_entry.valid & out_entry.ill;
    CSR_address_wb = out_entry.valid ? out_entry.addr : 12'd0;
  end

`ifndef SYNTHESIS
  logic [31:0]           cycle_q, cycle_d;
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic                  scan_window;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    for (int i = 0; i < int'(PIPE_DEPTH); i++) stage_valid[i] = pipe_q[i].valid;
    // Unsigned wrap-around makes this a single range test for [MIN, MAX]
    scan_window = ((cycle_q - SCAN_CYCLES_MIN) <= (SCAN_CYCLES_MAX - SCAN_CYCLES_MIN));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  always_ff @(posedge clock) begin
    if (scan && scan_window) begin
      $display("csr_pipe core %0d cycle %0d valid %b r%b w%b s%b c%b ill%b addr %h stall %b",
               CORE, cycle_q, stage_valid, CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en,
               csr_illegal, CSR_address_wb, csr_stall);
    end
  end
`endif

endmodule
